if_fetch_queue: RTL and testbench



---
 rtl/if_pkg.sv | 12 +
 rtl/if_fetch_fifo.sv | 52 +++++
 rtl/if_fetch_queue.sv | 118 +++++++++++
 tb/tb_if_fetch_queue.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package if_pkg;
  localparam int XLEN_DEF = 16;
  localparam int ILEN_DEF = 16;
  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;
  localparam int INSTR_BYTES_DEF = ILEN_DEF / 8;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_fifo.sv
// Generic DEPTH-entry circular FIFO with push/pop/flush and occupancy count.
module if_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & ~empty;
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(do_push && !do_pop && count == (AW+1)'(DEPTH)));
endmodule

// File: rtl/if_fetch_queue.sv
// Fetch front end: PC, 1-cycle imem issue, response queue to ID.
// Optional perf counters enabled by defining IF_FETCH_PERF_EN.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int              XLEN        = 16,
  parameter int              ILEN        = 16,
  parameter int              DEPTH       = 4,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEF),
  parameter int              INSTR_BYTES = ILEN / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_en,
  input  logic                      redirect_en,
  input  logic [XLEN-1:0]           redirect_pc,
  output logic                      imem_req,
  output logic [XLEN-1:0]           imem_addr,
  input  logic [ILEN-1:0]           imem_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [XLEN-1:0]           out_pc_next,
  output logic [ILEN-1:0]           out_instr,
  output logic [$clog2(DEPTH):0]    q_count
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]               perf_fetched,
  output logic [31:0]               perf_bubbles,
  output logic [31:0]               perf_flushed
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Same layout as fetch_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            push;
  logic            pop;
  logic            empty;
  entry_t          push_entry;
  entry_t          head_entry;

  // Slots are reserved at issue, so the in-flight request counts as occupied.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_req  = fetch_en & ~redirect_en & ~rst & (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = pc_q;

  assign push      = inflight & ~redirect_en;
  assign out_valid = ~empty & ~redirect_en;
  assign pop       = out_valid & out_ready;

  assign push_entry.pc    = inflight_pc;
  assign push_entry.instr = imem_rdata;

  // Issue stage: PC and in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (redirect_en)   pc_q <= redirect_pc;
      else if (imem_req) pc_q <= pc_q + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (imem_req) inflight_pc <= pc_q;
  end

  // Response stage: queue toward ID.
  if_fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_en),
    .din   (push_entry),
    .dout  (head_entry),
    .empty (empty),
    .count (count)
  );

  assign out_pc      = empty ? '0 : head_entry.pc;
  assign out_pc_next = empty ? '0 : head_entry.pc + XLEN'(INSTR_BYTES);
  assign out_instr   = empty ? '0 : head_entry.instr;
  assign q_count     = count;

`ifdef IF_FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && !(&v)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= sat_inc(perf_fetched, push);
      perf_bubbles <= sat_inc(perf_bubbles, out_ready & ~out_valid);
      perf_flushed <= sat_inc(perf_flushed, redirect_en);
    end
  end
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: directed phases push expected entries, a monitor pops on handshake.
module tb_if_fetch_queue;
  import if_pkg::*;

  typedef struct {
    fetch_entry_t ent;
    logic [15:0]  pc_next;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [15:0] out_pc_next;
  logic [15:0] out_instr;
  logic [2:0]  q_count;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
  logic [31:0] perf_flushed;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  if_fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_pc_next (out_pc_next),
    .out_instr   (out_instr),
    .q_count     (q_count)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles),
    .perf_flushed(perf_flushed)
`endif
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  // Instruction memory with 1-cycle read latency; unrequested cycles return junk.
  always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic expect_pc(input logic [15:0] pc, input logic [15:0] pc_next);
    exp_t e;
    e.ent.pc    = pc;
    e.ent.instr = mem_word(pc);
    e.pc_next   = pc_next;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: got pc %h with no expectation", out_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_pc", {16'h0, out_pc}, {16'h0, e.ent.pc});
        chk("out_pc_next", {16'h0, out_pc_next}, {16'h0, e.pc_next});
        chk("out_instr", {16'h0, out_instr}, {16'h0, e.ent.instr});
      end
    end
  end

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_en = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_q_count", {29'h0, q_count}, 32'h0);
    chk("rst_out_pc", {16'h0, out_pc}, 32'h0);
    chk("rst_out_pc_next", {16'h0, out_pc_next}, 32'h0);
    chk("rst_out_instr", {16'h0, out_instr}, 32'h0);
    cyc();

    // Streaming: five sequential requests, first output two cycles after release.
    rst = 1'b0; fetch_en = 1'b1;
    expect_pc(16'h0000, 16'h0002); expect_pc(16'h0002, 16'h0004);
    expect_pc(16'h0004, 16'h0006); expect_pc(16'h0006, 16'h0008);
    expect_pc(16'h0008, 16'h000A);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stream_addr", {16'h0, imem_addr}, 32'(2 * i));
      chk("stream_req", {31'h0, imem_req}, 32'h1);
      chk("stream_valid", {31'h0, out_valid}, (i >= 2) ? 32'h1 : 32'h0);
      cyc();
    end
    fetch_en = 1'b0;
    repeat (8) cyc();

    // Backpressure: queue fills to 4 and issue stops, then drains in order.
    rst = 1'b1; out_ready = 1'b0; fetch_en = 1'b1;
    cyc();
    rst = 1'b0;
    expect_pc(16'h0000, 16'h0002); expect_pc(16'h0002, 16'h0004);
    expect_pc(16'h0004, 16'h0006); expect_pc(16'h0006, 16'h0008);
    repeat (10) cyc();
    @(negedge clk);
    chk("full_q_count", {29'h0, q_count}, 32'd4);
    chk("full_imem_req", {31'h0, imem_req}, 32'h0);
    cyc();
    fetch_en = 1'b0; out_ready = 1'b1;
    repeat (6) cyc();

    // Redirect with 3 queued entries and one response in flight.
    rst = 1'b1; out_ready = 1'b0; fetch_en = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    chk("pre_redir_q_count", {29'h0, q_count}, 32'd3);
    redirect_en = 1'b1; redirect_pc = 16'h0100;
    #1;
    chk("redir_out_valid", {31'h0, out_valid}, 32'h0);
    chk("redir_imem_req", {31'h0, imem_req}, 32'h0);
    cyc();
    redirect_en = 1'b0; out_ready = 1'b1;
    expect_pc(16'h0100, 16'h0102); expect_pc(16'h0102, 16'h0104);
    expect_pc(16'h0104, 16'h0106);
    @(negedge clk);
    chk("post_redir_q_count", {29'h0, q_count}, 32'd0);
    chk("post_redir_addr", {16'h0, imem_addr}, 32'h0100);
    chk("post_redir_req", {31'h0, imem_req}, 32'h1);
    cyc(); cyc(); cyc();
    fetch_en = 1'b0;
    repeat (6) cyc();

    // PC wrap at the top of the address space.
    redirect_en = 1'b1; redirect_pc = 16'hFFFC; fetch_en = 1'b1;
    cyc();
    redirect_en = 1'b0;
    expect_pc(16'hFFFC, 16'hFFFE); expect_pc(16'hFFFE, 16'h0000);
    expect_pc(16'h0000, 16'h0002);
    @(negedge clk); chk("wrap_addr0", {16'h0, imem_addr}, 32'hFFFC); cyc();
    @(negedge clk); chk("wrap_addr1", {16'h0, imem_addr}, 32'hFFFE); cyc();
    @(negedge clk); chk("wrap_addr2", {16'h0, imem_addr}, 32'h0000); cyc();
    fetch_en = 1'b0;
    repeat (6) cyc();

    // Back-to-back redirects: the second target wins.
    redirect_en = 1'b1; redirect_pc = 16'h0200; fetch_en = 1'b1;
    cyc();
    redirect_pc = 16'h0300;
    cyc();
    redirect_en = 1'b0;
    expect_pc(16'h0300, 16'h0302);
    @(negedge clk);
    chk("b2b_addr", {16'h0, imem_addr}, 32'h0300);
    cyc();
    fetch_en = 1'b0;
    repeat (6) cyc();

    // Reset mid-stream with a loaded queue and a pending response.
    rst = 1'b1; out_ready = 1'b0; fetch_en = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    chk("pre_rst_q_count", {29'h0, q_count}, 32'd3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    expect_pc(16'h0000, 16'h0002);
    @(negedge clk);
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_q_count", {29'h0, q_count}, 32'd0);
    chk("midrst_addr", {16'h0, imem_addr}, 32'h0000);
    chk("midrst_req", {31'h0, imem_req}, 32'h1);
    cyc();
    fetch_en = 1'b0; out_ready = 1'b1;
    repeat (6) cyc();

`ifdef IF_FETCH_PERF_EN
    // 20 cycles: one redirect at cycle 10, ready low for cycles 0-1.
    rst = 1'b1; out_ready = 1'b0; fetch_en = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) expect_pc(16'(2 * i), 16'(2 * i + 2));
    for (int i = 0; i < 9; i++) expect_pc(16'h0400 + 16'(2 * i), 16'h0402 + 16'(2 * i));
    for (int c = 0; c < 20; c++) begin
      if (c == 2) out_ready = 1'b1;
      redirect_en = (c == 10);
      redirect_pc = 16'h0400;
      cyc();
    end
    fetch_en = 1'b0;
    @(negedge clk);
    chk("perf_flushed", perf_flushed, 32'd1);
    chk("perf_bubbles", perf_bubbles, 32'd3);
    chk("perf_fetched", perf_fetched, 32'd17);
    cyc();
    repeat (8) cyc();
`endif

    @(negedge clk);
    chk("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
